// File: rtl/uart_fifo_perif.sv
// 6502 bus-mapped UART: FIFO-buffered TX/RX with a runtime baud divisor.
// Define UART_PARITY_EN for 8E1 framing (11-bit frame); default build is 8N1.
// state | meaning: IDLE wait for data/start edge | START start bit | DATA 8 bits LSB first | PARITY even parity | STOP stop bit
`timescale 1ns/1ps
module uart_fifo_perif #(
    parameter int CLK_HZ   = 27000000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] AB,
    input  logic       CS,
    input  logic       WE,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       tx_pin,
    input  logic       rx_pin,
    output logic       irq,
    output logic       test_pin
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [DIV_W-1:0] DIV0    = DIV_W'(CLK_HZ / BAUD);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);
    localparam logic [DIV_W-1:0] D_ONE   = DIV_W'(1);
    localparam logic [TAW:0]     TX_FULL = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0]     RX_FULL = (RAW+1)'(RX_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_t;

    logic cs_q, acc, wr_acc, rd_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs_q <= 1'b0;
        else        cs_q <= CS;
    end

    assign acc    = CS & ~cs_q;
    assign wr_acc = acc & WE;
    assign rd_acc = acc & ~WE;

    logic [DIV_W-1:0] div_act, div_new;
    logic [7:0]       div_shadow;
    logic [15:0]      div_rd;

    assign div_new = DIV_W'({DI, div_shadow});
    assign div_rd  = 16'(div_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_act    <= DIV0;
            div_shadow <= 8'h00;
        end else if (wr_acc) begin
            if (AB == 2'd2) div_shadow <= DI;
            if (AB == 2'd3) div_act <= (div_new < DIV_MIN) ? DIV_MIN : div_new;
        end
    end

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [TAW:0]   tx_cnt;
    logic           tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt == TX_FULL);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = wr_acc && (AB == 2'd0) && !tx_full;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= DI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TAW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + (TAW+1)'(1);
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - (TAW+1)'(1);
        end
    end

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [RAW:0]   rx_cnt;
    logic           rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]     rx_sh, rx_sh_n;

    assign rx_full  = (rx_cnt == RX_FULL);
    assign rx_empty = (rx_cnt == '0);
    assign rx_pop   = rd_acc && (AB == 2'd0) && !rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + (RAW+1)'(1);
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - (RAW+1)'(1);
        end
    end

    uart_state_t      tx_state, tx_state_n;
    logic [7:0]       tx_sh, tx_sh_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [DIV_W-1:0] tx_tmr, tx_tmr_n, tx_div, tx_div_n;
    logic             tx_q, tx_line_n, tx_load;
`ifdef UART_PARITY_EN
    logic             tx_par, tx_par_n;
`endif

    always_comb begin
        tx_state_n = tx_state;
        tx_sh_n    = tx_sh;
        tx_bit_n   = tx_bit;
        tx_div_n   = tx_div;
        tx_tmr_n   = (tx_state == ST_IDLE) ? tx_tmr : tx_tmr - D_ONE;
        tx_load    = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            ST_IDLE:  tx_load = !tx_empty;
            ST_START: if (tx_tmr == '0) begin
                tx_state_n = ST_DATA;
                tx_tmr_n   = tx_div - D_ONE;
                tx_bit_n   = 3'd0;
            end
            ST_DATA: if (tx_tmr == '0) begin
                tx_sh_n  = {1'b0, tx_sh[7:1]};
                tx_tmr_n = tx_div - D_ONE;
                tx_bit_n = tx_bit + 3'd1;
                if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_state_n = ST_PARITY;
`else
                    tx_state_n = ST_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (tx_tmr == '0) begin
                tx_state_n = ST_STOP;
                tx_tmr_n   = tx_div - D_ONE;
            end
`endif
            ST_STOP: if (tx_tmr == '0) begin
                if (!tx_empty) tx_load = 1'b1;
                else           tx_state_n = ST_IDLE;
            end
            default: tx_state_n = ST_IDLE;
        endcase
        // Frame start (from IDLE or straight out of STOP): pop head, latch divisor.
        if (tx_load) begin
            tx_state_n = ST_START;
            tx_sh_n    = tx_mem[tx_rp];
            tx_div_n   = div_act;
            tx_tmr_n   = div_act - D_ONE;
`ifdef UART_PARITY_EN
            tx_par_n   = ^tx_mem[tx_rp];
`endif
        end
        tx_line_n = 1'b1;
        case (tx_state_n)
            ST_START:  tx_line_n = 1'b0;
            ST_DATA:   tx_line_n = tx_sh_n[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_line_n = tx_par_n;
`endif
            default:   tx_line_n = 1'b1;
        endcase
    end

    assign tx_pop = tx_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= ST_IDLE;
            tx_sh    <= 8'h00;
            tx_bit   <= 3'd0;
            tx_tmr   <= '0;
            tx_div   <= DIV0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_sh    <= tx_sh_n;
            tx_bit   <= tx_bit_n;
            tx_tmr   <= tx_tmr_n;
            tx_div   <= tx_div_n;
            tx_q     <= tx_line_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    assign tx_pin   = tx_q;
    assign test_pin = (tx_state != ST_IDLE);

    uart_state_t      rx_state, rx_state_n;
    logic             rx_s1, rx_s2, rx_s3, rx_bad;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [DIV_W-1:0] rx_tmr, rx_tmr_n, rx_div, rx_div_n;
    logic             rx_ferr, rx_overrun, ferr_set, ovr_set, stat_rd;
`ifdef UART_PARITY_EN
    logic             rx_perr, rx_perr_n;

    assign rx_bad = !rx_s2 || rx_perr;
`else
    assign rx_bad = !rx_s2;
`endif

    always_comb begin
        rx_state_n = rx_state;
        rx_sh_n    = rx_sh;
        rx_bit_n   = rx_bit;
        rx_div_n   = rx_div;
        rx_tmr_n   = (rx_state == ST_IDLE) ? rx_tmr : rx_tmr - D_ONE;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        ovr_set    = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_n  = rx_perr;
`endif
        case (rx_state)
            ST_IDLE: if (rx_s3 && !rx_s2) begin
                rx_state_n = ST_START;
                rx_div_n   = div_act;
                rx_tmr_n   = (div_act >> 1) - D_ONE;
            end
            ST_START: if (rx_tmr == '0) begin
                rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
                rx_tmr_n   = rx_div - D_ONE;
                rx_bit_n   = 3'd0;
            end
            ST_DATA: if (rx_tmr == '0) begin
                rx_sh_n  = {rx_s2, rx_sh[7:1]};
                rx_tmr_n = rx_div - D_ONE;
                rx_bit_n = rx_bit + 3'd1;
                if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                    rx_state_n = ST_PARITY;
`else
                    rx_state_n = ST_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (rx_tmr == '0) begin
                rx_perr_n  = rx_s2 ^ (^rx_sh);
                rx_state_n = ST_STOP;
                rx_tmr_n   = rx_div - D_ONE;
            end
`endif
            // Leave at the mid-stop sample so the next start edge is caught cleanly.
            ST_STOP: if (rx_tmr == '0) begin
                rx_state_n = ST_IDLE;
                if (rx_bad)       ferr_set = 1'b1;
                else if (rx_full) ovr_set  = 1'b1;
                else              rx_push  = 1'b1;
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    assign stat_rd = rd_acc && (AB == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            rx_state   <= ST_IDLE;
            rx_sh      <= 8'h00;
            rx_bit     <= 3'd0;
            rx_tmr     <= '0;
            rx_div     <= DIV0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr    <= 1'b0;
`endif
        end else begin
            rx_s1    <= rx_pin;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_n;
            rx_sh    <= rx_sh_n;
            rx_bit   <= rx_bit_n;
            rx_tmr   <= rx_tmr_n;
            rx_div   <= rx_div_n;
`ifdef UART_PARITY_EN
            rx_perr  <= rx_perr_n;
`endif
            if (ferr_set)     rx_ferr <= 1'b1;
            else if (stat_rd) rx_ferr <= 1'b0;
            if (ovr_set)      rx_overrun <= 1'b1;
            else if (stat_rd) rx_overrun <= 1'b0;
        end
    end

    logic [7:0] rd_data;

    always_comb begin
        rd_data = 8'h00;
        case (AB)
            2'd0: rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp];
            2'd1: rd_data = {2'b00, rx_ferr, test_pin, rx_overrun, !rx_empty, tx_empty, tx_full};
            2'd2: rd_data = div_rd[7:0];
            2'd3: rd_data = div_rd[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    assign DO  = (CS && !WE) ? rd_data : 8'bz;
    assign irq = !rx_empty || rx_overrun || rx_ferr;
endmodule
